// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding controller: forwarding
// select encoding, flush bit positions and the shadow scoreboard entries.
package pipe_pkg;

    // Scoreboard register fields are stored at this width; narrower REG_AW is zero-extended.
    localparam int SB_AW = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    localparam int FLUSH_IFID  = 0;
    localparam int FLUSH_IDEX  = 1;
    localparam int FLUSH_EXMEM = 2;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } sb_entry_t;

    typedef struct packed {
        sb_entry_t        sb;
        logic [SB_AW-1:0] rs1;
        logic [SB_AW-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
    } ex_entry_t;

    function automatic logic sb_match(sb_entry_t e, logic [SB_AW-1:0] r);
        return e.valid & e.reg_write & (e.rd != '0) & (e.rd == r);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: a shadow EX/MEM/WB scoreboard drives
// load-use stalls, EX operand forwarding selects and branch flushes.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FWD_EN       = 1,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              br_taken,
    output logic              stall,
    output logic [2:0]        flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [SB_AW-1:0] id_rs1_x, id_rs2_x, id_rd_x;
    ex_entry_t        ex_q, ex_d;
    sb_entry_t        mem_q, mem_d, wb_q, wb_d;
    logic             hit_ex, hit_mem, stall_req;
    fwd_sel_t         fwd_a_sel, fwd_b_sel;
    logic [2:0]       flush_w;
    logic             unused_ok;

    assign id_rs1_x = SB_AW'(id_rs1);
    assign id_rs2_x = SB_AW'(id_rs2);
    assign id_rd_x  = SB_AW'(id_rd);

    function automatic fwd_sel_t fwd_pick(logic en, logic [SB_AW-1:0] rs,
                                          sb_entry_t m, sb_entry_t w);
        if (en && sb_match(m, rs)) return FWD_MEM;
        if (en && sb_match(w, rs)) return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        hit_ex  = (id_use_rs1 & sb_match(ex_q.sb, id_rs1_x)) |
                  (id_use_rs2 & sb_match(ex_q.sb, id_rs2_x));
        hit_mem = (id_use_rs1 & sb_match(mem_q, id_rs1_x)) |
                  (id_use_rs2 & sb_match(mem_q, id_rs2_x));
        // Without forwarding the consumer waits until the producer sits in WB.
        if (FWD_EN != 0) stall_req = hit_ex & ex_q.sb.mem_read;
        else             stall_req = hit_ex | hit_mem;
    end

    // Gating with reset drops a pending stall before any clock edge.
    assign stall = id_valid & stall_req & ~br_taken & ~reset;

    always_comb begin
        flush_w = '0;
        if (br_taken && !reset) begin
            flush_w[FLUSH_IFID] = 1'b1;
            flush_w[FLUSH_IDEX] = 1'b1;
            if (BRANCH_STAGE == 3) flush_w[FLUSH_EXMEM] = 1'b1;
        end
    end

    assign flush = flush_w;

    always_comb begin
        fwd_a_sel = fwd_pick(ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
        fwd_b_sel = fwd_pick(ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
    end

    assign fwd_a = (FWD_EN != 0) ? fwd_a_sel : FWD_RF;
    assign fwd_b = (FWD_EN != 0) ? fwd_b_sel : FWD_RF;

    always_comb begin
        ex_d.sb.valid     = id_valid & ~stall & ~br_taken;
        ex_d.sb.rd        = id_rd_x;
        ex_d.sb.reg_write = id_reg_write;
        ex_d.sb.mem_read  = id_mem_read;
        ex_d.rs1          = id_rs1_x;
        ex_d.rs2          = id_rs2_x;
        ex_d.use_rs1      = id_use_rs1;
        ex_d.use_rs2      = id_use_rs2;
        mem_d             = ex_q.sb;
        // A branch resolved in MEM also squashes the wrong-path instruction leaving EX.
        if (br_taken && (BRANCH_STAGE == 3)) mem_d.valid = 1'b0;
        wb_d              = mem_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_taken),
        .cnt   (flush_cnt)
    );

    // Fields that some parameterisations leave unread.
    assign unused_ok = ^{hit_mem, ex_q.sb.mem_read, wb_q.mem_read,
                         ex_q.rs1, ex_q.rs2, ex_q.use_rs1, ex_q.use_rs2,
                         fwd_a_sel, fwd_b_sel};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: four parameterisations share one ID/branch
// stimulus stream; expected values are queued at drive time and popped at sample.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, br_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        a_stall, b_stall, c_stall, d_stall;
    logic [2:0]  a_flush, b_flush, c_flush, d_flush;
    logic [1:0]  a_fwda, b_fwda, c_fwda, d_fwda;
    logic [1:0]  a_fwdb, b_fwdb, c_fwdb, d_fwdb;
    logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt;
    logic [1:0]  d_scnt, d_fcnt;

    int n_chk  = 0;
    int n_pass = 0;

    localparam int IA = 0, IB = 1, IC = 2, ID = 3;
    localparam int STALL = 0, FLUSH = 1, FWDA = 2, FWDB = 3, SCNT = 4, FCNT = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // A: forwarding, MEM branch.  B: no forwarding.  C: EX branch.  D: 2-bit counters.
    hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BRANCH_STAGE(3), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
        .stall(a_stall), .flush(a_flush), .fwd_a(a_fwda), .fwd_b(a_fwdb),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

    hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .BRANCH_STAGE(3), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
        .stall(b_stall), .flush(b_flush), .fwd_a(b_fwda), .fwd_b(b_fwdb),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

    hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BRANCH_STAGE(2), .CNT_W(16)) u_c (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
        .stall(c_stall), .flush(c_flush), .fwd_a(c_fwda), .fwd_b(c_fwdb),
        .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

    hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BRANCH_STAGE(3), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
        .stall(d_stall), .flush(d_flush), .fwd_a(d_fwda), .fwd_b(d_fwdb),
        .stall_cnt(d_scnt), .flush_cnt(d_fcnt));

    function automatic logic [15:0] obs_of(int sel);
        case (sel)
            0:  return 16'(a_stall);
            1:  return 16'(a_flush);
            2:  return 16'(a_fwda);
            3:  return 16'(a_fwdb);
            4:  return a_scnt;
            5:  return a_fcnt;
            6:  return 16'(b_stall);
            7:  return 16'(b_flush);
            8:  return 16'(b_fwda);
            9:  return 16'(b_fwdb);
            10: return b_scnt;
            11: return b_fcnt;
            12: return 16'(c_stall);
            13: return 16'(c_flush);
            14: return 16'(c_fwda);
            15: return 16'(c_fwdb);
            16: return c_scnt;
            17: return c_fcnt;
            18: return 16'(d_stall);
            19: return 16'(d_flush);
            20: return 16'(d_fwda);
            21: return 16'(d_fwdb);
            22: return 16'(d_scnt);
            default: return 16'(d_fcnt);
        endcase
    endfunction

    task automatic expect_val(input int inst, input int field, input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = inst * 6 + field;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] o;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_of(e.sel);
            n_chk = n_chk + 1;
            assert (o === e.val) n_pass = n_pass + 1;
            else $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_use_rs1 = u1;  id_use_rs2 = u2;
        id_rd = rd;    id_reg_write = rw;  id_mem_read = mr;
    endtask

    task automatic bubble();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        br_taken = 1'b0;
        bubble();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        br_taken = 1'b0;
        bubble();
        #2;
        expect_val(IA, STALL, "rst_stall", 0);
        expect_val(IA, FLUSH, "rst_flush", 0);
        expect_val(IA, FWDA,  "rst_fwda",  0);
        expect_val(IA, FWDB,  "rst_fwdb",  0);
        expect_val(IA, SCNT,  "rst_scnt",  0);
        expect_val(IA, FCNT,  "rst_fcnt",  0);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Load-use: ld x5; add x6, x5, x7
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        expect_val(IA, STALL, "ldu_no_stall_yet", 0);
        drain();
        tick();
        set_id(1, 5, 7, 1, 1, 6, 1, 0);
        expect_val(IA, STALL, "ldu_stall", 1);
        drain();
        tick();
        expect_val(IA, STALL, "ldu_one_bubble", 0);
        drain();
        tick();
        bubble();
        expect_val(IA, FWDA, "ldu_fwda_wb", 2);
        expect_val(IA, FWDB, "ldu_fwdb_rf", 0);
        expect_val(IA, SCNT, "ldu_scnt", 1);
        drain();

        // ALU back-to-back, then with one independent instruction between
        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0);
        expect_val(IA, STALL, "alu_no_stall", 0);
        drain();
        tick();
        bubble();
        expect_val(IA, FWDA, "alu_fwda_mem", 1);
        expect_val(IA, FWDB, "alu_fwdb_mem", 1);
        expect_val(IA, SCNT, "alu_scnt", 0);
        drain();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_id(1, 1, 2, 1, 1, 9, 1, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0);
        expect_val(IA, STALL, "gap_no_stall", 0);
        drain();
        tick();
        bubble();
        expect_val(IA, FWDA, "gap_fwda_wb", 2);
        expect_val(IA, FWDB, "gap_fwdb_wb", 2);
        drain();

        // No forwarding: add x3; or x8, x3, x1
        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_id(1, 3, 1, 1, 1, 8, 1, 0);
        expect_val(IB, STALL, "nofwd_stall1", 1);
        expect_val(IB, FWDA,  "nofwd_fwda1", 0);
        expect_val(IB, FWDB,  "nofwd_fwdb1", 0);
        drain();
        tick();
        expect_val(IB, STALL, "nofwd_stall2", 1);
        expect_val(IB, FWDA,  "nofwd_fwda2", 0);
        drain();
        tick();
        expect_val(IB, STALL, "nofwd_wb_no_stall", 0);
        drain();
        tick();
        bubble();
        expect_val(IB, FWDA, "nofwd_fwda_tied", 0);
        expect_val(IB, FWDB, "nofwd_fwdb_tied", 0);
        expect_val(IB, SCNT, "nofwd_scnt", 2);
        drain();

        // x0 writer (a load) then x0 reader
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 1, 1, 7, 1, 0);
        expect_val(IA, STALL, "x0_no_stall_fwd", 0);
        expect_val(IB, STALL, "x0_no_stall_nofwd", 0);
        drain();
        tick();
        bubble();
        expect_val(IA, FWDA, "x0_fwda", 0);
        expect_val(IA, FWDB, "x0_fwdb", 0);
        drain();

        // Branch over a pending load-use stall
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 7, 1, 0, 6, 1, 0);
        expect_val(IA, STALL, "br_pending_stall", 1);
        drain();
        br_taken = 1'b1;
        expect_val(IA, STALL, "br_mem_stall_drop", 0);
        expect_val(IA, FLUSH, "br_mem_flush", 7);
        expect_val(IC, STALL, "br_ex_stall_drop", 0);
        expect_val(IC, FLUSH, "br_ex_flush", 3);
        drain();
        tick();
        br_taken = 1'b0;
        set_id(1, 6, 0, 1, 0, 10, 1, 0);
        expect_val(IA, FLUSH, "br_flush_one_cycle", 0);
        expect_val(IA, FWDA,  "br_mem_killed", 0);
        expect_val(IC, FWDA,  "br_ex_mem_kept", 1);
        expect_val(IA, FCNT,  "br_mem_fcnt", 1);
        expect_val(IC, FCNT,  "br_ex_fcnt", 1);
        expect_val(IA, SCNT,  "br_scnt_zero", 0);
        drain();
        tick();
        bubble();
        expect_val(IA, FWDA, "br_mem_ex_killed", 0);
        expect_val(IC, FWDA, "br_ex_ex_killed", 0);
        drain();
        br_taken = 1'b1;
        expect_val(IA, FLUSH, "b2b_mem_flush1", 7);
        expect_val(IC, FLUSH, "b2b_ex_flush1", 3);
        drain();
        tick();
        expect_val(IA, FLUSH, "b2b_mem_flush2", 7);
        expect_val(IC, FLUSH, "b2b_ex_flush2", 3);
        drain();
        tick();
        br_taken = 1'b0;
        expect_val(IA, FCNT,  "b2b_mem_fcnt", 3);
        expect_val(IC, FCNT,  "b2b_ex_fcnt", 3);
        expect_val(IA, FLUSH, "b2b_flush_off", 0);
        drain();

        // Saturating 2-bit stall counter, then reset mid-stall
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_id(1, 0, 0, 0, 0, 5, 1, 1);
            tick();
            set_id(1, 5, 5, 1, 1, 6, 1, 0);
            expect_val(ID, STALL, $sformatf("sat_stall%0d", k), 1);
            expect_val(ID, SCNT,  $sformatf("sat_cnt%0d", k), (k < 3) ? 16'(k) : 16'd3);
            drain();
            tick();
        end
        expect_val(ID, SCNT, "sat_cnt_final", 3);
        drain();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 5, 1, 1, 6, 1, 0);
        expect_val(ID, STALL, "pre_reset_stall", 1);
        drain();
        reset = 1'b1;
        expect_val(ID, STALL, "async_rst_stall", 0);
        expect_val(ID, SCNT,  "async_rst_scnt", 0);
        expect_val(IA, STALL, "async_rst_stall_a", 0);
        expect_val(IA, SCNT,  "async_rst_scnt_a", 0);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline (IF, IDRF, EX, MEM, WB).
- Keeps its own shadow scoreboard of the instructions in EX, MEM and WB.
- From that scoreboard it drives load-use stalls, operand forwarding selects for EX, and branch flushes.
- The branch-resolve stage and the forwarding mode are parameters, so the current and the next pipeline variants share one block.

Parameters:
REG_AW, 5, register address width (x0 is hardwired zero)
FWD_EN, 1, 1 = forwarding enabled; 0 = stall until the producer clears MEM
BRANCH_STAGE, 3, stage where br_taken is asserted: 2 = EX, 3 = MEM
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  instruction in IDRF is real (not a bubble)
id_rs1  in  REG_AW  IDRF source register 1
id_rs2  in  REG_AW  IDRF source register 2
id_use_rs1  in  1  IDRF instruction reads rs1
id_use_rs2  in  1  IDRF instruction reads rs2
id_rd  in  REG_AW  IDRF destination register
id_reg_write  in  1  IDRF instruction writes rd
id_mem_read  in  1  IDRF instruction is a load
br_taken  in  1  taken branch resolved in BRANCH_STAGE this cycle
stall  out  1  hold PC and the IF/ID register; insert a bubble into ID/EX
flush  out  3  bit0 clears IF/ID, bit1 clears ID/EX, bit2 clears EX/MEM
fwd_a  out  2  EX operand A source: 00 = RF, 01 = EX/MEM result, 10 = WB data
fwd_b  out  2  EX operand B source, same encoding
stall_cnt  out  CNT_W  cycles with stall asserted
flush_cnt  out  CNT_W  cycles with br_taken asserted

Behaviour:
Scoreboard
- Three entries, EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}.
- The EX entry also holds {rs1, rs2, use_rs1, use_rs2}.
- Every cycle: WB <= MEM, MEM <= EX, EX <= ID inputs (valid = id_valid).
- When stall is asserted, EX.valid is loaded with 0 (bubble) and MEM/WB still advance.

Match definition
- match(e, r) = e.valid & e.reg_write & (e.rd != 0) & (e.rd == r).
- A source register participates only when its use_rsN bit is 1.

Stall
- FWD_EN = 1: stall = id_valid & (used rs matches EX) & EX.mem_read. This is the load-use case; exactly one bubble is inserted.
- FWD_EN = 0: stall = id_valid & (used rs matches EX or MEM). The register file writes in the first half-cycle, so a match against WB does not stall.
- If br_taken is asserted, stall is forced to 0.

Forwarding
- Computed combinationally from registered state.
- fwd_a: 01 if EX.use_rs1 & match(MEM, EX.rs1); else 10 if match(WB, EX.rs1); else 00.
- fwd_b: the same rule using EX.rs2 and EX.use_rs2.
- MEM has priority over WB.
- FWD_EN = 0: fwd_a and fwd_b are tied to 00.

Flush
- br_taken with BRANCH_STAGE = 2: flush = 3'b011, and on the same edge EX.valid <= 0.
- br_taken with BRANCH_STAGE = 3: flush = 3'b111, and on the same edge EX.valid <= 0 and MEM.valid <= 0.
- flush is combinational from br_taken and lasts one cycle per br_taken cycle.

Counters
- stall_cnt and flush_cnt increment by 1 per qualifying cycle.
- Both saturate at all-ones and never wrap.

Reset
- Asynchronous: all scoreboard entries invalid, counters 0.
- stall = 0, flush = 0, fwd_a = fwd_b = 00.
- Reset asserted mid-stall drops stall immediately, without waiting for a clock edge.

Boundary conditions
- rd = 0 never matches anything.
- A load followed by a dependent use in both rs1 and rs2 still inserts only one bubble.
- Back-to-back br_taken cycles flush on each cycle.
- A stall request in the same cycle as br_taken is discarded.

Decomposition:
- Shared package pipe_pkg: fwd_sel_t enum (FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10), the flush bit-index constants, and the sb_entry_t struct.
- One natural sub-module, sat_counter (CNT_W, inc), instantiated twice for the performance counters.

Test Plan:
- FWD_EN = 1. Sequence: ld x5 (mem_read, rd = 5) followed by add x6, x5, x7 (use_rs1, rs1 = 5). Required: stall = 1 for exactly 1 cycle, EX bubble inserted, then fwd_a = 10 when the add reaches EX; stall_cnt = 1.
- FWD_EN = 1. Sequence: add x3 then sub x4, x3, x3. Required: no stall; fwd_a = fwd_b = 01 when sub is in EX. With one independent instruction between them: fwd_a = fwd_b = 10.
- FWD_EN = 0. Sequence: add x3 then or x8, x3, x1. Required: stall held for 2 cycles, fwd_a = fwd_b = 00 throughout, stall_cnt = 2.
- Writer with rd = x0 followed by a reader of x0. Required: no stall, fwd = 00.
- BRANCH_STAGE = 3, br_taken pulsed for 1 cycle while a load-use stall is pending. Required: flush = 3'b111, stall = 0, EX and MEM entries invalid on the next cycle, flush_cnt = 1. Repeat with BRANCH_STAGE = 2: flush = 3'b011.
- CNT_W = 2, drive 5 stall cycles. Required: stall_cnt saturates at 3. Then assert reset mid-stall. Required: stall = 0 and stall_cnt = 0 immediately, before the next clock edge.
